// File: rtl/ram_arbiter_pkg.sv
// rtl/ram_arbiter_pkg.sv - shared types, constants and grant helper for ram_arbiter
package ram_arbiter_pkg;

  typedef logic client_t;

  localparam client_t CLIENT0 = 1'b0;
  localparam client_t CLIENT1 = 1'b1;
  localparam int      CNT_W   = 16;

  // Two-client round-robin grant: a lone requester always wins, a tie goes to ptr.
  function automatic logic [1:0] rr_grant(input logic v0, input logic v1, input client_t ptr);
    logic [1:0] g;
    g[0] = v0 && (!v1 || ptr == CLIENT0);
    g[1] = v1 && (!v0 || ptr == CLIENT1);
    return g;
  endfunction

endpackage

// File: rtl/ram_arbiter_ram.sv
// rtl/ram_arbiter_ram.sv - single-clock dual-port RAM, registered read, read-before-write
module ram_arbiter_ram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 64,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rden,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] q,
  input  logic             wren,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Both updates are non-blocking, so a same-address read sees the pre-write word.
  always_ff @(posedge clk) begin
    if (wren) mem[waddr] <= wdata;
    if (rden) q <= mem[raddr];
  end

endmodule

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - two-client round-robin arbiter in front of a shared RAM
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 64,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             c0_rd_valid,
  input  logic [AW-1:0]    c0_rd_addr,
  output logic             c0_rd_ready,
  output logic             c0_rsp_valid,
  output logic [WIDTH-1:0] c0_rsp_data,
  input  logic             c0_wr_valid,
  input  logic [AW-1:0]    c0_wr_addr,
  input  logic [WIDTH-1:0] c0_wr_data,
  output logic             c0_wr_ready,
  input  logic             c1_rd_valid,
  input  logic [AW-1:0]    c1_rd_addr,
  output logic             c1_rd_ready,
  output logic             c1_rsp_valid,
  output logic [WIDTH-1:0] c1_rsp_data,
  input  logic             c1_wr_valid,
  input  logic [AW-1:0]    c1_wr_addr,
  input  logic [WIDTH-1:0] c1_wr_data,
  output logic             c1_wr_ready,
  output logic [CNT_W-1:0] conflict_cnt
);

  client_t          rd_ptr, wr_ptr, rsp_tag;
  logic             rsp_pending;
  logic [1:0]       rd_gnt, wr_gnt;
  logic             rden, wren;
  logic [AW-1:0]    raddr, waddr;
  logic [WIDTH-1:0] wdata, q;
  logic [1:0]       conflict_inc;
  logic [CNT_W:0]   cnt_sum;

  always_comb begin
    rd_gnt = rst ? 2'b00 : rr_grant(c0_rd_valid, c1_rd_valid, rd_ptr);
    wr_gnt = rst ? 2'b00 : rr_grant(c0_wr_valid, c1_wr_valid, wr_ptr);
  end

  assign c0_rd_ready = rd_gnt[0];
  assign c1_rd_ready = rd_gnt[1];
  assign c0_wr_ready = wr_gnt[0];
  assign c1_wr_ready = wr_gnt[1];

  assign rden  = |rd_gnt;
  assign raddr = rd_gnt[1] ? c1_rd_addr : c0_rd_addr;
  assign wren  = |wr_gnt;
  assign waddr = wr_gnt[1] ? c1_wr_addr : c0_wr_addr;
  assign wdata = wr_gnt[1] ? c1_wr_data : c0_wr_data;

  assign conflict_inc = {1'b0, c0_rd_valid & c1_rd_valid} + {1'b0, c0_wr_valid & c1_wr_valid};
  assign cnt_sum      = {1'b0, conflict_cnt} + {{(CNT_W-1){1'b0}}, conflict_inc};

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr       <= CLIENT0;
      wr_ptr       <= CLIENT0;
      rsp_tag      <= CLIENT0;
      rsp_pending  <= 1'b0;
      conflict_cnt <= '0;
    end else begin
      // The pointer moves to whichever client was not served; idle ports hold.
      if (rden) rd_ptr <= rd_gnt[0] ? CLIENT1 : CLIENT0;
      if (wren) wr_ptr <= wr_gnt[0] ? CLIENT1 : CLIENT0;
      rsp_pending <= rden;
      if (rden) rsp_tag <= rd_gnt[1] ? CLIENT1 : CLIENT0;
      conflict_cnt <= cnt_sum[CNT_W] ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
    end
  end

  // A response landing in a reset cycle is suppressed so an interrupted read never reports.
  assign c0_rsp_valid = rsp_pending && rsp_tag == CLIENT0 && !rst;
  assign c1_rsp_valid = rsp_pending && rsp_tag == CLIENT1 && !rst;
  assign c0_rsp_data  = c0_rsp_valid ? q : '0;
  assign c1_rsp_data  = c1_rsp_valid ? q : '0;

  ram_arbiter_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) ram (
    .clk   (clk),
    .rden  (rden),
    .raddr (raddr),
    .q     (q),
    .wren  (wren),
    .waddr (waddr),
    .wdata (wdata)
  );

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - directed self-checking bench for ram_arbiter
module tb_ram_arbiter;

  localparam int WIDTH = 8;
  localparam int DEPTH = 64;
  localparam int AW    = 6;

  logic             clk = 1'b0;
  logic             rst;
  logic             c0_rd_valid, c1_rd_valid, c0_wr_valid, c1_wr_valid;
  logic [AW-1:0]    c0_rd_addr, c1_rd_addr, c0_wr_addr, c1_wr_addr;
  logic [WIDTH-1:0] c0_wr_data, c1_wr_data;
  logic             c0_rd_ready, c1_rd_ready, c0_wr_ready, c1_wr_ready;
  logic             c0_rsp_valid, c1_rsp_valid;
  logic [WIDTH-1:0] c0_rsp_data, c1_rsp_data;
  logic [15:0]      conflict_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ram_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .c0_rd_valid(c0_rd_valid), .c0_rd_addr(c0_rd_addr), .c0_rd_ready(c0_rd_ready),
    .c0_rsp_valid(c0_rsp_valid), .c0_rsp_data(c0_rsp_data),
    .c0_wr_valid(c0_wr_valid), .c0_wr_addr(c0_wr_addr), .c0_wr_data(c0_wr_data),
    .c0_wr_ready(c0_wr_ready),
    .c1_rd_valid(c1_rd_valid), .c1_rd_addr(c1_rd_addr), .c1_rd_ready(c1_rd_ready),
    .c1_rsp_valid(c1_rsp_valid), .c1_rsp_data(c1_rsp_data),
    .c1_wr_valid(c1_wr_valid), .c1_wr_addr(c1_wr_addr), .c1_wr_data(c1_wr_data),
    .c1_wr_ready(c1_wr_ready),
    .conflict_cnt(conflict_cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    c0_rd_valid = 0; c1_rd_valid = 0; c0_wr_valid = 0; c1_wr_valid = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    c0_rd_addr = 0; c1_rd_addr = 0; c0_wr_addr = 0; c1_wr_addr = 0;
    c0_wr_data = 0; c1_wr_data = 0;
    rst = 1'b1;
    c0_rd_valid = 1; c1_rd_valid = 1; c0_wr_valid = 1; c1_wr_valid = 1;
    step(); step();
    checks++; if ({c0_rd_ready, c1_rd_ready, c0_wr_ready, c1_wr_ready} !== 4'b0000) begin errors++; $display("FAIL reset_readys got=%b exp=0000", {c0_rd_ready, c1_rd_ready, c0_wr_ready, c1_wr_ready}); end
    checks++; if (conflict_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", conflict_cnt); end
    checks++; if ({c0_rsp_valid, c1_rsp_valid} !== 2'b00) begin errors++; $display("FAIL reset_rsp_valid got=%b exp=00", {c0_rsp_valid, c1_rsp_valid}); end
    idle();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_write_read();
    c0_wr_valid = 1; c0_wr_addr = 3; c0_wr_data = 8'hA5;
    #1;
    checks++; if ({c0_wr_ready, c1_wr_ready} !== 2'b10) begin errors++; $display("FAIL wr_single_ready got=%b exp=10", {c0_wr_ready, c1_wr_ready}); end
    step();
    idle();
    c0_rd_valid = 1; c0_rd_addr = 3;
    #1;
    checks++; if (c0_rd_ready !== 1'b1) begin errors++; $display("FAIL rd_single_ready got=%b exp=1", c0_rd_ready); end
    checks++; if (c0_rsp_valid !== 1'b0) begin errors++; $display("FAIL rsp_before_grant got=%b exp=0", c0_rsp_valid); end
    step();
    idle();
    #1;
    checks++; if (c0_rsp_valid !== 1'b1 || c0_rsp_data !== 8'hA5) begin errors++; $display("FAIL rsp_latency got=%b/%h exp=1/a5", c0_rsp_valid, c0_rsp_data); end
    checks++; if (c1_rsp_valid !== 1'b0) begin errors++; $display("FAIL rsp_other_client got=%b exp=0", c1_rsp_valid); end
    step();
    checks++; if (c0_rsp_valid !== 1'b0 || c0_rsp_data !== 8'h00) begin errors++; $display("FAIL rsp_one_cycle got=%b/%h exp=0/00", c0_rsp_valid, c0_rsp_data); end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_c0;
    exp_c0 = 4'b0101;
    do_reset();
    c0_rd_valid = 1; c0_rd_addr = 0; c1_rd_valid = 1; c1_rd_addr = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if ({c0_rd_ready, c1_rd_ready} !== {exp_c0[i], ~exp_c0[i]}) begin errors++; $display("FAIL rr_grant_%0d got=%b exp=%b", i, {c0_rd_ready, c1_rd_ready}, {exp_c0[i], ~exp_c0[i]}); end
      step();
      checks++; if ({c0_rsp_valid, c1_rsp_valid} !== {exp_c0[i], ~exp_c0[i]}) begin errors++; $display("FAIL rr_rsp_%0d got=%b exp=%b", i, {c0_rsp_valid, c1_rsp_valid}, {exp_c0[i], ~exp_c0[i]}); end
    end
    idle();
    #1;
    checks++; if (conflict_cnt !== 16'd4) begin errors++; $display("FAIL rr_cnt got=%0d exp=4", conflict_cnt); end
  endtask

  task automatic test_collision();
    do_reset();
    c0_wr_valid = 1; c0_wr_addr = 5; c0_wr_data = 8'h11;
    step();
    c0_wr_data = 8'h22; c1_rd_valid = 1; c1_rd_addr = 5;
    step();
    idle();
    #1;
    checks++; if (c1_rsp_valid !== 1'b1 || c1_rsp_data !== 8'h11) begin errors++; $display("FAIL collide_old got=%b/%h exp=1/11", c1_rsp_valid, c1_rsp_data); end
    c1_rd_valid = 1; c1_rd_addr = 5;
    step();
    idle();
    #1;
    checks++; if (c1_rsp_valid !== 1'b1 || c1_rsp_data !== 8'h22) begin errors++; $display("FAIL collide_new got=%b/%h exp=1/22", c1_rsp_valid, c1_rsp_data); end
  endtask

  task automatic test_write_arb();
    logic [1:0] exp_c0;
    exp_c0 = 2'b01;
    do_reset();
    c0_wr_valid = 1; c0_wr_addr = 7; c0_wr_data = 8'h01;
    c1_wr_valid = 1; c1_wr_addr = 7; c1_wr_data = 8'h02;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++; if ({c0_wr_ready, c1_wr_ready} !== {exp_c0[i], ~exp_c0[i]}) begin errors++; $display("FAIL wr_arb_%0d got=%b exp=%b", i, {c0_wr_ready, c1_wr_ready}, {exp_c0[i], ~exp_c0[i]}); end
      step();
    end
    idle();
    #1;
    checks++; if (conflict_cnt !== 16'd2) begin errors++; $display("FAIL wr_arb_cnt got=%0d exp=2", conflict_cnt); end
  endtask

  task automatic test_back_to_back();
    c0_rd_valid = 1; c0_rd_addr = 3;
    step();
    checks++; if (c0_rsp_valid !== 1'b1 || c0_rsp_data !== 8'hA5) begin errors++; $display("FAIL b2b_0 got=%b/%h exp=1/a5", c0_rsp_valid, c0_rsp_data); end
    c0_rd_addr = 7;
    step();
    checks++; if (c0_rsp_valid !== 1'b1 || c0_rsp_data !== 8'h02) begin errors++; $display("FAIL b2b_1 got=%b/%h exp=1/02", c0_rsp_valid, c0_rsp_data); end
    c0_rd_valid = 0; c1_rd_valid = 1; c1_rd_addr = 5;
    step();
    checks++; if ({c0_rsp_valid, c1_rsp_valid} !== 2'b01 || c1_rsp_data !== 8'h22) begin errors++; $display("FAIL b2b_2 got=%b/%h exp=01/22", {c0_rsp_valid, c1_rsp_valid}, c1_rsp_data); end
    idle();
    step();
    checks++; if ({c0_rsp_valid, c1_rsp_valid} !== 2'b00) begin errors++; $display("FAIL b2b_drain got=%b exp=00", {c0_rsp_valid, c1_rsp_valid}); end
  endtask

  task automatic test_reset_mid_read();
    do_reset();
    c0_wr_valid = 1; c0_wr_addr = 9; c0_wr_data = 8'h33;
    c1_rd_valid = 1; c1_rd_addr = 3;
    #1;
    checks++; if (c1_rd_ready !== 1'b1) begin errors++; $display("FAIL mid_grant got=%b exp=1", c1_rd_ready); end
    step();
    idle();
    rst = 1'b1;
    #1;
    checks++; if ({c0_rsp_valid, c1_rsp_valid} !== 2'b00) begin errors++; $display("FAIL mid_no_rsp got=%b exp=00", {c0_rsp_valid, c1_rsp_valid}); end
    step();
    rst = 1'b0;
    #1;
    checks++; if ({c0_rsp_valid, c1_rsp_valid} !== 2'b00) begin errors++; $display("FAIL mid_after_rst got=%b exp=00", {c0_rsp_valid, c1_rsp_valid}); end
    c0_rd_valid = 1; c1_rd_valid = 1; c0_wr_valid = 1; c1_wr_valid = 1;
    #1;
    checks++; if ({c0_rd_ready, c1_rd_ready, c0_wr_ready, c1_wr_ready} !== 4'b1010) begin errors++; $display("FAIL mid_ptrs got=%b exp=1010", {c0_rd_ready, c1_rd_ready, c0_wr_ready, c1_wr_ready}); end
    idle();
    #1;
  endtask

  task automatic test_saturation();
    do_reset();
    c0_rd_valid = 1; c1_rd_valid = 1; c0_wr_valid = 1; c1_wr_valid = 1;
    c0_wr_addr = 20; c1_wr_addr = 21;
    repeat (32767) step();
    checks++; if (conflict_cnt !== 16'd65534) begin errors++; $display("FAIL sat_near got=%0d exp=65534", conflict_cnt); end
    c0_wr_valid = 0;
    step();
    checks++; if (conflict_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_reach got=%h exp=ffff", conflict_cnt); end
    c0_wr_valid = 1;
    repeat (2000) step();
    checks++; if (conflict_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_hold got=%h exp=ffff", conflict_cnt); end
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_write_read();
    test_round_robin();
    test_collision();
    test_write_arb();
    test_back_to_back();
    test_reset_mid_read();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter WIDTH, default 8, is the data word width in bits.
REQ-002 Parameter DEPTH, default 64, is the number of words; AW = $clog2(DEPTH).
REQ-003 clk  input  1  is the single clock; all logic updates on the rising edge.
REQ-004 rst  input  1  is the synchronous, active-high reset.
REQ-005 cN_rd_valid  input  1  means client N (N = 0, 1) requests a read.
REQ-006 cN_rd_addr  input  AW  is the read address of client N.
REQ-007 cN_rd_ready  output  1  is the combinational read grant to client N this cycle.
REQ-008 cN_rsp_valid  output  1  means cN_rsp_data holds client N's read data.
REQ-009 cN_rsp_data  output  WIDTH  is the read data returned to client N.
REQ-010 cN_wr_valid  input  1  means client N requests a write.
REQ-011 cN_wr_addr  input  AW  is the write address of client N.
REQ-012 cN_wr_data  input  WIDTH  is the write data of client N.
REQ-013 cN_wr_ready  output  1  is the combinational write grant to client N this cycle.
REQ-014 conflict_cnt  output  16  counts cycles in which both clients requested the same port.

Function
REQ-015 A read transfers when cN_rd_valid and cN_rd_ready are both high at a clock edge; writes follow the same rule.
REQ-016 Read and write ports are arbitrated independently; each port grants at most one client per cycle.
REQ-017 Each port keeps a 1-bit round-robin pointer naming the favoured client; when both clients request, the favoured client is granted and the pointer flips to the other client.
REQ-018 A single requester is granted immediately, whatever the pointer value; the pointer then moves to the non-granted client.
REQ-019 When there is no request, the pointer holds its value.
REQ-020 cN_rd_ready and cN_wr_ready depend only on the valids and the pointer; they never depend on a ready.
REQ-021 On a granted read, drive the RAM rden high with the winner's address, and register the winner's index as rsp_tag.
REQ-022 Read latency is exactly 1 cycle: cN_rsp_valid is high in the cycle after the grant, only for N = rsp_tag, and only for one cycle.
REQ-023 cN_rsp_data equals RAM q while cN_rsp_valid is high; otherwise it is all zeros.
REQ-024 On a granted write, drive the RAM wren high with the winner's address and data.
REQ-025 A read and a write to the same address in the same cycle return the old contents (read-before-write).
REQ-026 Back-to-back reads in consecutive cycles are fully pipelined, one grant per cycle with no bubble.
REQ-027 conflict_cnt increments by 1 per port that sees both valids in a cycle (so by 2 if both ports conflict); it saturates at 0xFFFF.
REQ-028 A conflict on one port does not affect grants or the pointer of the other port.

Reset
REQ-029 rst high at a clock edge sets both pointers to 0 (client 0 favoured), clears rsp_tag and both cN_rsp_valid, and clears conflict_cnt to 0.
REQ-030 While rst is high, all ready outputs are 0 and RAM rden and wren are held low.
REQ-031 A read granted in the cycle before rst asserts produces no response.
REQ-032 RAM contents are not cleared by reset.

Structure
REQ-033 The block instantiates exactly one sub-module, ram, with matching WIDTH and DEPTH.
REQ-034 The client-index type (1 bit) and the counter width constant (16) belong in the shared package; WIDTH and DEPTH stay module parameters.

Verification
REQ-035 Write/read single client: c0 writes 0xA5 to address 3, then reads address 3 -> c0_rsp_valid goes high exactly 1 cycle after the read grant with data 0xA5; c1_rsp_valid stays 0.
REQ-036 Round-robin: both clients hold rd_valid for 4 cycles after reset -> grants go c0, c1, c0, c1, and conflict_cnt = 4.
REQ-037 Same-address collision: address 5 holds 0x11; c0 writes 0x22 to 5 while c1 reads 5 in the same cycle -> c1 gets 0x11; a following read returns 0x22.
REQ-038 Write arbitration: both clients write address 7 (c0 0x01, c1 0x02) for 2 cycles from reset -> final contents 0x02, and conflict_cnt = 2.
REQ-039 Reset mid-read: c1 is granted a read, then rst is asserted the next cycle -> no cN_rsp_valid pulse, and the pointers return to 0.
REQ-040 Saturation: force 70000 conflict cycles -> conflict_cnt holds at 0xFFFF.
